// File: rtl/hangman_pkg.sv
// Shared types, letter codes and slot helpers for the hangman game controller.
package hangman_pkg;

    localparam int NUM_SLOTS    = 6;
    localparam int WORD_W       = 5 * NUM_SLOTS;
    localparam int NUM_LETTERS  = 26;
    localparam int LETTER_MAX   = 25;
    localparam int LETTER_DASH  = 27;
    localparam int LETTER_BLANK = 31;

    typedef enum logic [3:0] {
        ST_START  = 4'd0,
        ST_INGAME = 4'd1,
        ST_WIN    = 4'd2,
        ST_LOST   = 4'd3
    } game_state_e;

    typedef enum logic [2:0] {
        FSM_IDLE = 3'd0,
        FSM_PLAY = 3'd1,
        FSM_EVAL = 3'd2,
        FSM_WIN  = 3'd3,
        FSM_LOSE = 3'd4
    } fsm_e;

    // Slot 0 lives in the top five bits of the word.
    function automatic logic [4:0] slot_code(input logic [WORD_W-1:0] w, input int idx);
        return 5'(w >> (5 * (NUM_SLOTS - 1 - idx)));
    endfunction

    function automatic logic [NUM_LETTERS-1:0] letter_onehot(input logic [4:0] letter);
        return (letter <= 5'(LETTER_MAX)) ? (26'd1 << letter) : 26'd0;
    endfunction

endpackage

// File: rtl/hangman_game_ctrl_word_matcher.sv
// Combinational slot scanner: letter hit, full reveal and first still-hidden used slot.
module word_matcher
    import hangman_pkg::*;
(
    input  logic [WORD_W-1:0]      word,
    input  logic [NUM_LETTERS-1:0] mask,
    input  logic [4:0]             letter,
    output logic                   hit,
    output logic                   all_revealed,
    output logic [2:0]             first_hidden_slot
);

    // Walk the slots in order; unused slots (code above LETTER_MAX) never count.
    always_comb begin
        logic [4:0] code_v;
        logic       used_v;
        logic       hidden_v;
        logic       found_v;
        hit               = 1'b0;
        all_revealed      = 1'b1;
        first_hidden_slot = 3'd0;
        found_v           = 1'b0;
        code_v            = 5'd0;
        used_v            = 1'b0;
        hidden_v          = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            code_v            = slot_code(word, i);
            used_v            = (code_v <= 5'(LETTER_MAX));
            hidden_v          = used_v && ((mask & letter_onehot(code_v)) == 26'd0);
            hit               = hit | (used_v && (code_v == letter));
            all_revealed      = all_revealed & ~hidden_v;
            first_hidden_slot = (hidden_v && !found_v) ? 3'(i) : first_hidden_slot;
            found_v           = found_v | hidden_v;
        end
    end

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman game controller: latches the word, scores guesses, drives renderer outputs.
// Optional hint feature is built when HANGMAN_HINT_EN is defined.
module hangman_game_ctrl
    import hangman_pkg::*;
#(
    parameter int MAX_WRONG = 6
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   new_game,
    input  logic [WORD_W-1:0]      word_in,
    input  logic                   guess_valid,
    input  logic [4:0]             guess_letter,
`ifdef HANGMAN_HINT_EN
    input  logic                   hint_req,
`endif
    output logic                   guess_ready,
    output logic [3:0]             state,
    output logic [WORD_W-1:0]      word,
    output logic [NUM_LETTERS-1:0] mask,
    output logic [3:0]             wrong_count
);

    fsm_e                   fsm_r;
    logic                   hit_s;
    logic                   all_revealed_s;
    logic [2:0]             first_hidden_slot_s;
    logic [NUM_LETTERS-1:0] guess_bit_s;
    logic                   fresh_guess_s;
    logic [3:0]             wrong_inc_s;

    word_matcher u_matcher (
        .word              (word),
        .mask              (mask),
        .letter            (guess_letter),
        .hit               (hit_s),
        .all_revealed      (all_revealed_s),
        .first_hidden_slot (first_hidden_slot_s)
    );

    // Guess decode and saturating penalty increment
    always_comb begin
        guess_bit_s   = letter_onehot(guess_letter);
        fresh_guess_s = ((guess_bit_s & ~mask) != 26'd0);
        if (wrong_count < 4'(MAX_WRONG)) begin
            wrong_inc_s = wrong_count + 4'd1;
        end else begin
            wrong_inc_s = wrong_count;
        end
    end

`ifdef HANGMAN_HINT_EN
    logic [NUM_LETTERS-1:0] hint_bit_s;

    // Letter held by the lowest hidden used slot
    always_comb begin
        hint_bit_s = letter_onehot(slot_code(word, int'(first_hidden_slot_s)));
    end
`else
    logic [2:0] unused_hint_slot_s;
    assign unused_hint_slot_s = first_hidden_slot_s;
`endif

    // Game FSM with all outputs registered alongside the state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fsm_r       <= FSM_IDLE;
            state       <= ST_START;
            word        <= {NUM_SLOTS{5'(LETTER_BLANK)}};
            mask        <= 26'd0;
            wrong_count <= 4'd0;
            guess_ready <= 1'b0;
        end else if (new_game) begin
            fsm_r       <= FSM_PLAY;
            state       <= ST_INGAME;
            word        <= word_in;
            mask        <= 26'd0;
            wrong_count <= 4'd0;
            guess_ready <= 1'b1;
        end else begin
            case (fsm_r)
                FSM_PLAY: begin
                    if (guess_valid) begin
                        // Invalid or repeated letters are accepted but cost nothing.
                        if (fresh_guess_s) begin
                            mask        <= mask | guess_bit_s;
                            wrong_count <= hit_s ? wrong_count : wrong_inc_s;
                            fsm_r       <= FSM_EVAL;
                            guess_ready <= 1'b0;
                        end
                    end
`ifdef HANGMAN_HINT_EN
                    else if (hint_req && !all_revealed_s) begin
                        mask        <= mask | hint_bit_s;
                        wrong_count <= wrong_inc_s;
                        fsm_r       <= FSM_EVAL;
                        guess_ready <= 1'b0;
                    end
`endif
                end
                FSM_EVAL: begin
                    if (all_revealed_s) begin
                        fsm_r <= FSM_WIN;
                        state <= ST_WIN;
                    end else if (wrong_count >= 4'(MAX_WRONG)) begin
                        fsm_r <= FSM_LOSE;
                        state <= ST_LOST;
                    end else begin
                        fsm_r       <= FSM_PLAY;
                        guess_ready <= 1'b1;
                    end
                end
                FSM_IDLE, FSM_WIN, FSM_LOSE: begin
                    fsm_r <= fsm_r;
                end
                default: begin
                    fsm_r       <= FSM_IDLE;
                    state       <= ST_START;
                    guess_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
